// File: rtl/jfpjc_frame_sequencer_if.sv
// rtl/jfpjc_frame_sequencer_if.sv - output byte stream between frame sequencer and byte sink
//
// Signals:
//   out_valid  byte present on out_data
//   out_data   byte value
//   out_sof    with out_valid: first byte of a file
//   out_eof    with out_valid: last byte of a file
//   out_ready  sink accepts the byte when out_valid & out_ready
// Modports: master = sequencer side, slave = sink side.

interface jfpjc_frame_sequencer_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/jfpjc_frame_sequencer.sv
// rtl/jfpjc_frame_sequencer.sv - emits header, scan bytes and EOI as one JPEG file per frame
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   frame_start            one-cycle request for a new file (honoured only when idle)
//   scan_valid/scan_data   compressor byte strobe and byte
//   scan_done              last scan byte of the frame has been presented
//   header_rom_*           header ROM read port (data one cycle after ren)
//   qtable_*               quantization table read port and ownership select
//   out_if                 output byte stream (master side)
//   busy                   file in progress
//   overflow               sticky: a scan byte was dropped on a full FIFO
// Build option: JFPJC_QTABLE_PATCH_EN - when defined, header bytes
//   QUANT_TABLE_OFFSET..+63 are read from the quantization table instead of the ROM.

module jfpjc_frame_sequencer #(
    parameter int HEADER_LEN         = 328,
    parameter int QUANT_TABLE_OFFSET = 25,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_data,
    input  logic                          scan_done,
    output logic [8:0]                    header_rom_raddr,
    output logic                          header_rom_ren,
    input  logic [7:0]                    header_rom_dout,
    output logic [5:0]                    qtable_raddr,
    output logic                          qtable_ren,
    output logic                          qtable_sel,
    input  logic [7:0]                    qtable_dout,
    jfpjc_frame_sequencer_if.master       out_if,
    output logic                          busy,
    output logic                          overflow
);

`ifdef JFPJC_QTABLE_PATCH_EN
    localparam bit PATCH_EN = 1'b1;
`else
    localparam bit PATCH_EN = 1'b0;
`endif

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [8:0]     HDR_END  = 9'(HEADER_LEN);
    localparam logic [8:0]     Q_LO     = 9'(QUANT_TABLE_OFFSET);
    localparam logic [8:0]     Q_HI     = 9'(QUANT_TABLE_OFFSET + 64);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SCAN, S_EOI0, S_EOI1} state_t;
    state_t state, state_nx;

    logic [8:0]  rd_idx;                 // next header index to read
    logic        rd_pending, rd_pend_sof, rd_pend_q;
    logic        skid_valid, skid_sof;
    logic [7:0]  skid_data;
    logic        out_valid_r, out_sof_r, out_eof_r;
    logic [7:0]  out_data_r;
    logic        done_flag;
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    logic        fs_accept, out_fire, out_free;
    logic [1:0]  occ, occ_after;
    logic        hdr_issue, issue_q;
    logic [8:0]  issue_idx;
    logic [7:0]  arrive_data;
    logic [AW:0] fifo_count;
    logic        fifo_empty, fifo_full, fifo_pop, push_req, push_ok;
    logic        hdr_done, scan_to_eoi;

    always_comb begin
        fs_accept  = (state == S_IDLE) && frame_start;
        out_fire   = out_valid_r && out_if.out_ready;
        out_free   = !out_valid_r || out_if.out_ready;

        // Header bytes live in the output register, the skid or the ROM
        // pipeline; a read is issued only if its byte will have a slot.
        occ        = 2'(out_valid_r) + 2'(skid_valid) + 2'(rd_pending);
        occ_after  = occ - 2'(out_fire);
        issue_idx  = fs_accept ? 9'd0 : rd_idx;
        hdr_issue  = fs_accept ||
                     ((state == S_HDR) && (rd_idx < HDR_END) && (occ_after <= 2'd1));
        issue_q    = PATCH_EN && hdr_issue && (issue_idx >= Q_LO) && (issue_idx < Q_HI);

        header_rom_ren   = hdr_issue && !issue_q;
        header_rom_raddr = header_rom_ren ? issue_idx : 9'd0;
        qtable_ren       = issue_q;
        qtable_raddr     = issue_q ? 6'(issue_idx - Q_LO) : 6'd0;
        qtable_sel       = PATCH_EN && (state == S_HDR);
        arrive_data      = rd_pend_q ? qtable_dout : header_rom_dout;

        fifo_count = wr_ptr - rd_ptr;
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == FULL_CNT);
        fifo_pop   = (state == S_SCAN) && !fifo_empty && out_free;
        push_req   = scan_valid && ((state == S_HDR) || (state == S_SCAN));
        push_ok    = push_req && (!fifo_full || fifo_pop);

        // Last header byte leaves when nothing else of the header is queued.
        hdr_done    = (state == S_HDR) && (rd_idx == HDR_END) && !rd_pending &&
                      !skid_valid && out_fire;
        scan_to_eoi = (state == S_SCAN) && done_flag && fifo_empty && !out_valid_r;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != S_IDLE);
        case (state)
            S_IDLE:  if (frame_start) state_nx = S_HDR;
            S_HDR:   if (hdr_done)    state_nx = S_SCAN;
            S_SCAN:  if (scan_to_eoi) state_nx = S_EOI0;
            S_EOI0:  if (out_fire)    state_nx = S_EOI1;
            S_EOI1:  if (out_fire)    state_nx = S_IDLE;
            default:                  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock) begin
        if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= scan_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_idx      <= '0;
            rd_pending  <= 1'b0;
            rd_pend_sof <= 1'b0;
            rd_pend_q   <= 1'b0;
            skid_valid  <= 1'b0;
            skid_sof    <= 1'b0;
            skid_data   <= '0;
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eof_r   <= 1'b0;
            out_data_r  <= '0;
            done_flag   <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (fs_accept) begin
                done_flag <= 1'b0;
                overflow  <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
            end else begin
                if (scan_done && (state != S_IDLE))         done_flag <= 1'b1;
                if (push_req && fifo_full && !fifo_pop)     overflow  <= 1'b1;
                if (push_ok)                                wr_ptr    <= wr_ptr + 1'b1;
                if (fifo_pop)                               rd_ptr    <= rd_ptr + 1'b1;
            end

            if (hdr_issue) rd_idx <= issue_idx + 9'd1;
            rd_pending  <= hdr_issue;
            rd_pend_sof <= (issue_idx == 9'd0);
            rd_pend_q   <= issue_q;

            if (out_free) begin
                if (skid_valid) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= skid_data;
                    out_sof_r   <= skid_sof;
                    out_eof_r   <= 1'b0;
                    skid_valid  <= rd_pending;
                    skid_data   <= arrive_data;
                    skid_sof    <= rd_pend_sof;
                end else if (rd_pending) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= arrive_data;
                    out_sof_r   <= rd_pend_sof;
                    out_eof_r   <= 1'b0;
                end else if (fifo_pop) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= fifo_mem[rd_ptr[AW-1:0]];
                    out_sof_r   <= 1'b0;
                    out_eof_r   <= 1'b0;
                end else if (scan_to_eoi) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= 8'hFF;
                    out_sof_r   <= 1'b0;
                    out_eof_r   <= 1'b0;
                end else if ((state == S_EOI0) && out_fire) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= 8'hD9;
                    out_sof_r   <= 1'b0;
                    out_eof_r   <= 1'b1;
                end else if (out_fire) begin
                    out_valid_r <= 1'b0;
                    out_sof_r   <= 1'b0;
                    out_eof_r   <= 1'b0;
                end
            end else if (rd_pending) begin
                skid_valid <= 1'b1;
                skid_data  <= arrive_data;
                skid_sof   <= rd_pend_sof;
            end
        end
    end

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_sof   = out_sof_r;
    assign out_if.out_eof   = out_eof_r;

endmodule
